// File: rtl/matmul_operand_feeder_if.sv
// Operand/feed bus between the job issuer (master) and the matmul operand feeder (slave).
// Carries the start handshake, dimensions, operand sets and the skewed PE-edge feed.
interface matmul_operand_feeder_if #(
   parameter int DATA_WIDTH = 32,
   parameter int BUS_WIDTH  = 64,
   parameter int MAX_DIM    = BUS_WIDTH/DATA_WIDTH,
   parameter int DIM_W      = 2
);
   logic                                  start_i;
   logic [DIM_W-1:0]                      N_i, K_i, M_i;
   logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0] operandA_i, operandB_i;
   logic [MAX_DIM*DATA_WIDTH-1:0]         a_o, b_o;
   logic                                  valid_o, pe_clear_o, busy_o, done_o, err_o;

   modport master (
      output start_i, N_i, K_i, M_i, operandA_i, operandB_i,
      input  a_o, b_o, valid_o, pe_clear_o, busy_o, done_o, err_o
   );

   modport slave (
      input  start_i, N_i, K_i, M_i, operandA_i, operandB_i,
      output a_o, b_o, valid_o, pe_clear_o, busy_o, done_o, err_o
   );
endinterface

// File: rtl/matmul_operand_feeder.sv
// Latches an A/B operand set and streams skewed, zero-padded edge vectors into the PE grid.
// Define MATMUL_FEEDER_SHORT_DRAIN_EN to end the feed once the active N x M sub-grid is covered.
module matmul_operand_feeder #(
   parameter int DATA_WIDTH = 32,
   parameter int BUS_WIDTH  = 64,
   parameter int MAX_DIM    = BUS_WIDTH/DATA_WIDTH,
   parameter int DIM_W      = 2
) (
   input logic                   clk_i,
   input logic                   rst_i,
   matmul_operand_feeder_if.slave bus
);
   localparam int TW  = $clog2(3*MAX_DIM-1);
   localparam int OPW = MAX_DIM*MAX_DIM*DATA_WIDTH;
   localparam int VW  = MAX_DIM*DATA_WIDTH;

   typedef enum logic [1:0] {IDLE, CLEAR, FEED, DONE} state_e;

   state_e           state_q;
   logic [OPW-1:0]   opa_q, opb_q;
   logic [DIM_W-1:0] n_q, k_q, m_q;
   logic [TW-1:0]    t_q, t_nx, t_last;
   logic [VW-1:0]    a_q, b_q, a_d, b_d;
   logic             valid_q, clr_q, busy_q, done_q, err_q;
   logic             dims_ok;

   assign dims_ok = (int'(bus.N_i) >= 1) && (int'(bus.N_i) <= MAX_DIM) &&
                    (int'(bus.K_i) >= 1) && (int'(bus.K_i) <= MAX_DIM) &&
                    (int'(bus.M_i) >= 1) && (int'(bus.M_i) <= MAX_DIM);

`ifdef MATMUL_FEEDER_SHORT_DRAIN_EN
   assign t_last = TW'(k_q) + TW'(n_q) + TW'(m_q) - TW'(3);
`else
   assign t_last = TW'(k_q) + TW'(2*MAX_DIM-3);
`endif

   // Beat index that the output registers will present after the next edge.
   assign t_nx = (state_q == CLEAR) ? '0 : t_q + TW'(1);

   // Row i carries A[i][c] and column i carries B[c][i] on beat i+c.
   always_comb begin
      a_d = '0;
      b_d = '0;
      for (int i = 0; i < MAX_DIM; i++) begin
         for (int c = 0; c < MAX_DIM; c++) begin
            if (int'(t_nx) == i + c && c < int'(k_q)) begin
               if (i < int'(n_q))
                  a_d[i*DATA_WIDTH +: DATA_WIDTH] = opa_q[(i*MAX_DIM+c)*DATA_WIDTH +: DATA_WIDTH];
               if (i < int'(m_q))
                  b_d[i*DATA_WIDTH +: DATA_WIDTH] = opb_q[(c*MAX_DIM+i)*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         n_q     <= '0;
         k_q     <= '0;
         m_q     <= '0;
         t_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         valid_q <= 1'b0;
         clr_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         clr_q  <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start_i) begin
                  if (dims_ok) begin
                     opa_q   <= bus.operandA_i;
                     opb_q   <= bus.operandB_i;
                     n_q     <= bus.N_i;
                     k_q     <= bus.K_i;
                     m_q     <= bus.M_i;
                     t_q     <= '0;
                     clr_q   <= 1'b1;
                     busy_q  <= 1'b1;
                     state_q <= CLEAR;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            CLEAR: begin
               valid_q <= 1'b1;
               a_q     <= a_d;
               b_q     <= b_d;
               t_q     <= t_nx;
               state_q <= FEED;
            end
            FEED: begin
               if (t_q == t_last) begin
                  valid_q <= 1'b0;
                  a_q     <= '0;
                  b_q     <= '0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  a_q <= a_d;
                  b_q <= b_d;
                  t_q <= t_nx;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.a_o        = a_q;
   assign bus.b_o        = b_q;
   assign bus.valid_o    = valid_q;
   assign bus.pe_clear_o = clr_q;
   assign bus.busy_o     = busy_q;
   assign bus.done_o     = done_q;
   assign bus.err_o      = err_q;
endmodule

// File: tb/tb_matmul_operand_feeder.sv
// Randomized bench for matmul_operand_feeder: every beat is compared with an
// edge-vector model built straight from the skew/zero-pad rules.
module tb_matmul_operand_feeder;
   localparam int DW   = 32;
   localparam int BW   = 64;
   localparam int MD   = BW/DW;
   localparam int DIMW = 2;
   localparam int OPW  = MD*MD*DW;
   localparam int VW   = MD*DW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   matmul_operand_feeder_if #(.DATA_WIDTH(DW), .BUS_WIDTH(BW), .MAX_DIM(MD), .DIM_W(DIMW)) bus ();

   matmul_operand_feeder #(.DATA_WIDTH(DW), .BUS_WIDTH(BW), .MAX_DIM(MD), .DIM_W(DIMW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [OPW-1:0] got, input logic [OPW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // {valid, pe_clear, busy, done, err}
   function automatic logic [4:0] ctl();
      return {bus.valid_o, bus.pe_clear_o, bus.busy_o, bus.done_o, bus.err_o};
   endfunction

   function automatic logic [VW-1:0] exp_a(input logic [OPW-1:0] op, input int n, input int k, input int t);
      logic [DW-1:0] m [MD][MD];
      logic [VW-1:0] v;
      v = '0;
      for (int r = 0; r < MD; r++)
         for (int c = 0; c < MD; c++)
            m[r][c] = op[(r*MD+c)*DW +: DW];
      for (int i = 0; i < MD; i++)
         if (i < n && t - i >= 0 && t - i < k) v[i*DW +: DW] = m[i][t-i];
      return v;
   endfunction

   function automatic logic [VW-1:0] exp_b(input logic [OPW-1:0] op, input int mm, input int k, input int t);
      logic [DW-1:0] m [MD][MD];
      logic [VW-1:0] v;
      v = '0;
      for (int r = 0; r < MD; r++)
         for (int c = 0; c < MD; c++)
            m[r][c] = op[(r*MD+c)*DW +: DW];
      for (int j = 0; j < MD; j++)
         if (j < mm && t - j >= 0 && t - j < k) v[j*DW +: DW] = m[t-j][j];
      return v;
   endfunction

   function automatic logic [OPW-1:0] rnd_op();
      logic [OPW-1:0] v;
      for (int w = 0; w < OPW/32; w++) v[w*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic run_job(input logic [OPW-1:0] oa, input logic [OPW-1:0] ob,
                          input int n, input int k, input int m, input bit hold, input bit mutate);
      int nbeats;
`ifdef MATMUL_FEEDER_SHORT_DRAIN_EN
      nbeats = k + n + m - 2;
`else
      nbeats = k + 2*MD - 2;
`endif
      @(negedge clk);
      bus.start_i    = 1'b1;
      bus.N_i        = DIMW'(n);
      bus.K_i        = DIMW'(k);
      bus.M_i        = DIMW'(m);
      bus.operandA_i = oa;
      bus.operandB_i = ob;
      @(posedge clk); #1;
      chk("clear_ctl", OPW'(ctl()), OPW'(5'b01100));
      chk("clear_ab", OPW'({bus.a_o, bus.b_o}), '0);
      @(negedge clk);
      if (!hold) bus.start_i = 1'b0;
      if (mutate) begin
         bus.operandA_i = ~oa;
         bus.operandB_i = rnd_op();
         bus.N_i        = DIMW'($urandom_range(0, 3));
         bus.K_i        = DIMW'($urandom_range(0, 3));
         bus.M_i        = DIMW'($urandom_range(0, 3));
      end
      for (int t = 0; t < nbeats; t++) begin
         @(posedge clk); #1;
         chk("feed_ctl", OPW'(ctl()), OPW'(5'b10100));
         chk("feed_a", OPW'(bus.a_o), OPW'(exp_a(oa, n, k, t)));
         chk("feed_b", OPW'(bus.b_o), OPW'(exp_b(ob, m, k, t)));
      end
      @(posedge clk); #1;
      chk("done_ctl", OPW'(ctl()), OPW'(5'b00110));
      chk("done_ab", OPW'({bus.a_o, bus.b_o}), '0);
      @(posedge clk); #1;
      chk("idle_ctl", OPW'(ctl()), OPW'(5'b00000));
   endtask

   task automatic bad_start(input int n, input int k, input int m);
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.N_i     = DIMW'(n);
      bus.K_i     = DIMW'(k);
      bus.M_i     = DIMW'(m);
      @(posedge clk); #1;
      chk("err_ctl", OPW'(ctl()), OPW'(5'b00001));
      @(negedge clk);
      bus.start_i = 1'b0;
      @(posedge clk); #1;
      chk("err_clr", OPW'(ctl()), OPW'(5'b00000));
   endtask

   initial begin
      logic [OPW-1:0] oa, ob;
      bus.start_i    = 1'b0;
      bus.N_i        = '0;
      bus.K_i        = '0;
      bus.M_i        = '0;
      bus.operandA_i = '0;
      bus.operandB_i = '0;

      #12;
      chk("rst_ctl", OPW'(ctl()), OPW'(5'b00000));
      chk("rst_ab", OPW'({bus.a_o, bus.b_o}), '0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_ctl", OPW'(ctl()), OPW'(5'b00000));

      // A=[[1,2],[3,4]], B=[[5,6],[7,8]] with element [r][c] at word r*MD+c
      oa = {32'd4, 32'd3, 32'd2, 32'd1};
      ob = {32'd8, 32'd7, 32'd6, 32'd5};
      run_job(oa, ob, 2, 2, 2, 1'b0, 1'b0);
      run_job(oa, ob, 1, 2, 1, 1'b0, 1'b1);

      bad_start(2, 0, 2);
      bad_start(3, 2, 2);

      // Reset in the middle of the second feed beat aborts the job silently.
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.N_i = 2'd2; bus.K_i = 2'd2; bus.M_i = 2'd2;
      bus.operandA_i = oa; bus.operandB_i = ob;
      @(posedge clk);
      @(negedge clk);
      bus.start_i = 1'b0;
      @(posedge clk);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("midrst_ctl", OPW'(ctl()), OPW'(5'b00000));
      chk("midrst_ab", OPW'({bus.a_o, bus.b_o}), '0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         chk("after_rst_quiet", OPW'(ctl()), OPW'(5'b00000));
      end
      run_job(oa, ob, 2, 2, 2, 1'b0, 1'b0);

      for (int it = 0; it < 30; it++) begin
         run_job(rnd_op(), rnd_op(), int'($urandom_range(1, MD)), int'($urandom_range(1, MD)),
                 int'($urandom_range(1, MD)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      @(negedge clk);
      bus.start_i = 1'b0;
      @(posedge clk); #1;
      chk("final_idle", OPW'(ctl()), OPW'(5'b00000));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
